mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the memory port arbiter
//
// Purpose: FSM state, transaction owner and dmem operation encodings used by
// mem_port_arbiter and its bench.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    IMEM = 1'b0,
    DMEM = 1'b1
  } owner_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_RSVD_2 = 2'b10;
  localparam logic [1:0] OP_RSVD_3 = 2'b11;

  // Reserved encodings fall through to a read.
  function automatic logic op_is_write(input logic [1:0] op);
    return op == OP_WRITE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (imem/dmem) arbiter onto one single-port memory
//
// Purpose: accepts one instruction-fetch or data request at a time, issues it to
// the memory for one cycle, waits for the completion strobe and routes it back.
// dmem has priority; imem is guaranteed a grant after STARVE_LIMIT consecutive
// dmem grants made while it was waiting.
//
// Ports:
//   clock, reset            - sole clock; asynchronous active-low reset
//   imem_req_*              - fetch request (valid/ready/addr)
//   imem_resp_*             - fetch completion pulse and data
//   dmem_req_*              - data request (valid/ready/addr/wdata/op)
//   dmem_resp_*             - data completion pulse and load data (0 for writes)
//   mem_req_*               - request strobe and payload toward the memory
//   mem_resp_*              - memory completion strobe and read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_req_valid,
  output logic        imem_req_ready,
  input  logic [31:0] imem_req_addr,
  output logic        imem_resp_valid,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_wdata,
  input  logic [1:0]  dmem_req_op,
  output logic        dmem_resp_valid,
  output logic [31:0] dmem_resp_data,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic        mem_req_write,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state;
  owner_t      owner;
  logic [3:0]  starve_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;

  logic        starved;
  logic        dmem_win;
  logic        imem_win;
  logic        busy;
  logic        resp_fire;
  logic [31:0] resp_data;

  // imem overrides dmem priority only once it has been passed over LIMIT times.
  assign starved  = imem_req_valid && (starve_cnt == LIMIT);
  assign dmem_win = dmem_req_valid && !starved;
  assign imem_win = imem_req_valid && !dmem_win;

  assign dmem_req_ready = (state == IDLE) && dmem_win;
  assign imem_req_ready = (state == IDLE) && imem_win;

  // Payload is only driven while a transaction is in flight.
  assign busy          = (state != IDLE);
  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = busy ? addr_q  : 32'h0;
  assign mem_req_wdata = busy ? wdata_q : 32'h0;
  assign mem_req_write = busy && write_q;

  // Completion strobes outside WAIT are stale and dropped.
  assign resp_fire = (state == WAIT) && mem_resp_valid;
  assign resp_data = write_q ? 32'h0 : mem_resp_data;

  assign dmem_resp_valid = resp_fire && (owner == DMEM);
  assign imem_resp_valid = resp_fire && (owner == IMEM);
  assign dmem_resp_data  = dmem_resp_valid ? resp_data : 32'h0;
  assign imem_resp_data  = imem_resp_valid ? resp_data : 32'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= DMEM;
      starve_cnt <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_win) begin
            owner   <= DMEM;
            addr_q  <= dmem_req_addr;
            wdata_q <= dmem_req_wdata;
            write_q <= op_is_write(dmem_req_op);
            state   <= ISSUE;
            if (!imem_req_valid) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (imem_win) begin
            owner      <= IMEM;
            addr_q     <= imem_req_addr;
            wdata_q    <= 32'h0;
            write_q    <= 1'b0;
            starve_cnt <= 4'd0;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_resp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid = 1'b0;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr = 32'h0;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid = 1'b0;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr = 32'h0;
  logic [31:0] dmem_req_wdata = 32'h0;
  logic [1:0]  dmem_req_op = 2'b00;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_write;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_op(dmem_req_op), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_write(mem_req_write),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Memory contents as seen by reads.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: answers mem_lat cycles after the request strobe; writes get junk data.
  int          mem_lat = 1;
  int          mem_cd = 0;
  logic [31:0] mem_pend = 32'h0;
  bit          idle_pulse = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (mem_req_valid === 1'b1) begin
        mem_cd   = mem_lat;
        mem_pend = mem_fn(mem_req_addr);
      end
      @(posedge clock);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_pend;
        end
      end
      if (idle_pulse) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        idle_pulse     = 1'b0;
      end
    end
  end

  // Transaction-level model state.
  bit          m_busy = 0, m_issue = 0, m_own_d = 0, m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  int          m_starve = 0;

  // Observed-event log for the literal checks.
  int          n_dacc = 0, n_iacc = 0, n_dresp = 0, n_iresp = 0;
  int          acc_cyc = 0, resp_cyc = 0;
  logic [31:0] last_dresp_data = 0, last_iresp_data = 0;
  logic [31:0] last_issue_addr = 0, last_issue_wdata = 0;
  logic        last_issue_write = 0;
  int          gcount = 0;
  logic [31:0] gbits = 0;

  initial begin : compare_proc
    logic        e_ir, e_dr, e_mv, e_mw, e_irv, e_drv;
    logic [31:0] e_ma, e_mwd, e_ird, e_drd;
    bit          win_d, win_i;
    forever begin
      @(negedge clock);
      cyc++;

      if (dmem_req_valid && dmem_req_ready) begin
        n_dacc++; acc_cyc = cyc;
        if (gcount < 32) gbits[gcount] = 1'b0;
        gcount++;
      end
      if (imem_req_valid && imem_req_ready) begin
        n_iacc++; acc_cyc = cyc;
        if (gcount < 32) gbits[gcount] = 1'b1;
        gcount++;
      end
      if (mem_req_valid === 1'b1) begin
        last_issue_addr  = mem_req_addr;
        last_issue_wdata = mem_req_wdata;
        last_issue_write = mem_req_write;
      end
      if (dmem_resp_valid === 1'b1) begin
        n_dresp++; resp_cyc = cyc; last_dresp_data = dmem_resp_data;
      end
      if (imem_resp_valid === 1'b1) begin
        n_iresp++; resp_cyc = cyc; last_iresp_data = imem_resp_data;
      end

      e_ir = 0; e_dr = 0; e_mv = 0; e_mw = 0; e_irv = 0; e_drv = 0;
      e_ma = 0; e_mwd = 0; e_ird = 0; e_drd = 0;
      win_d = 0; win_i = 0;
      if (reset) begin
        if (!m_busy) begin
          win_d = dmem_req_valid && !(imem_req_valid && m_starve == LIMIT);
          win_i = imem_req_valid && !win_d;
          e_dr  = win_d;
          e_ir  = win_i;
        end else begin
          e_ma  = m_addr;
          e_mwd = m_wdata;
          e_mw  = m_wr;
          if (m_issue) begin
            e_mv = 1;
          end else if (mem_resp_valid) begin
            if (m_own_d) begin
              e_drv = 1; e_drd = m_wr ? 32'h0 : mem_resp_data;
            end else begin
              e_irv = 1; e_ird = mem_resp_data;
            end
          end
        end
      end

      chk("imem_req_ready", imem_req_ready, e_ir);
      chk("dmem_req_ready", dmem_req_ready, e_dr);
      chk("mem_req_valid", mem_req_valid, e_mv);
      chk("mem_req_addr", mem_req_addr, e_ma);
      chk("mem_req_wdata", mem_req_wdata, e_mwd);
      chk("mem_req_write", mem_req_write, e_mw);
      chk("imem_resp", {imem_resp_valid, imem_resp_data[30:0]}, {e_irv, e_ird[30:0]});
      chk("imem_resp_data", imem_resp_data, e_ird);
      chk("dmem_resp_valid", dmem_resp_valid, e_drv);
      chk("dmem_resp_data", dmem_resp_data, e_drd);

      if (!reset) begin
        m_busy = 0; m_issue = 0; m_starve = 0; m_own_d = 1; m_wr = 0;
        m_addr = 0; m_wdata = 0;
      end else if (!m_busy) begin
        if (win_d) begin
          m_busy = 1; m_issue = 1; m_own_d = 1;
          m_addr = dmem_req_addr; m_wdata = dmem_req_wdata;
          m_wr = (dmem_req_op == OP_WRITE);
          m_starve = imem_req_valid ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end else if (win_i) begin
          m_busy = 1; m_issue = 1; m_own_d = 0;
          m_addr = imem_req_addr; m_wdata = 0; m_wr = 0;
          m_starve = 0;
        end
      end else if (m_issue) begin
        m_issue = 0;
      end else if (mem_resp_valid) begin
        m_busy = 0;
      end
    end
  end

  function automatic int evt(input int sel);
    case (sel)
      0:       return n_dacc;
      1:       return n_dresp;
      2:       return n_iacc;
      default: return n_iresp;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int base, input string name);
    int t = 0;
    while (evt(sel) == base && t < 50) begin
      @(posedge clock); #1; t++;
    end
    chk(name, 32'(evt(sel) > base), 32'd1);
  endtask

  task automatic dmem_txn(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] w, input string nm);
    int b_acc  = n_dacc;
    int b_resp = n_dresp;
    dmem_req_op = op; dmem_req_addr = a; dmem_req_wdata = w; dmem_req_valid = 1'b1;
    wait_evt(0, b_acc, {nm, "_accept"});
    dmem_req_valid = 1'b0;
    wait_evt(1, b_resp, {nm, "_resp"});
  endtask

  task automatic imem_txn(input logic [31:0] a, input string nm);
    int b_acc  = n_iacc;
    int b_resp = n_iresp;
    imem_req_addr = a; imem_req_valid = 1'b1;
    wait_evt(2, b_acc, {nm, "_accept"});
    imem_req_valid = 1'b0;
    wait_evt(3, b_resp, {nm, "_resp"});
  endtask

  // Both requesters held valid until n grants have been observed.
  task automatic starve_run(input int n, input string nm);
    int t = 0;
    gcount = 0; gbits = 32'h0;
    dmem_req_op = OP_READ; dmem_req_addr = 32'h500; dmem_req_wdata = 32'h0;
    imem_req_addr = 32'h80;
    dmem_req_valid = 1'b1; imem_req_valid = 1'b1;
    while (gcount < n && t < 200) begin
      @(posedge clock); #1; t++;
    end
    dmem_req_valid = 1'b0; imem_req_valid = 1'b0;
    chk({nm, "_grants"}, 32'(gcount), 32'(n));
    repeat (6) begin @(posedge clock); #1; end
  endtask

  initial begin
    int bd, bi;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;

    dmem_txn(OP_READ, 32'h100, 32'h0, "t1");
    chk("t1_issue_addr", last_issue_addr, 32'h100);
    chk("t1_resp_data", last_dresp_data, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(resp_cyc - acc_cyc), 32'd2);

    dmem_txn(OP_WRITE, 32'h200, 32'h1234_5678, "t2");
    chk("t2_issue_write", 32'(last_issue_write), 32'd1);
    chk("t2_issue_wdata", last_issue_wdata, 32'h1234_5678);
    chk("t2_resp_data", last_dresp_data, 32'h0);

    dmem_txn(OP_RSVD_3, 32'h300, 32'hFFFF_0000, "t3");
    chk("t3_issue_write", 32'(last_issue_write), 32'd0);
    chk("t3_resp_data", last_dresp_data, 32'hC0DE_0300);

    imem_txn(32'h40, "t4");
    chk("t4_issue_write", 32'(last_issue_write), 32'd0);
    chk("t4_resp_data", last_iresp_data, 32'hC0DE_0040);

    starve_run(10, "t5");
    chk("t5_grant_order", gbits, 32'h0000_0210);

    // Reset while waiting on a slow memory; the late strobe must be dropped.
    mem_lat = 3;
    bd = n_dacc;
    dmem_req_op = OP_READ; dmem_req_addr = 32'h400;
    dmem_req_valid = 1'b1; imem_req_valid = 1'b1;
    wait_evt(0, bd, "t6_accept");
    dmem_req_valid = 1'b0; imem_req_valid = 1'b0;
    mem_lat = 1;
    @(posedge clock); #1;
    bd = n_dresp; bi = n_iresp;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) begin @(posedge clock); #1; end
    chk("t6_no_dresp", 32'(n_dresp), 32'(bd));
    chk("t6_no_iresp", 32'(n_iresp), 32'(bi));
    starve_run(5, "t6_after");
    chk("t6_starve_cleared", gbits, 32'h0000_0010);

    bd = n_dresp; bi = n_iresp;
    @(negedge clock);
    idle_pulse = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    chk("t7_idle_no_dresp", 32'(n_dresp), 32'(bd));
    chk("t7_idle_no_iresp", 32'(n_iresp), 32'(bi));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
